// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot loader controller.
// Contents: FSM state encoding and the default inter-byte idle timeout.
package boot_loader_ctrl_pkg;

  typedef enum logic [2:0] {
    BL_LEN_LO  = 3'd0,
    BL_LEN_HI  = 3'd1,
    BL_DATA    = 3'd2,
    BL_WRITE   = 3'd3,
    BL_RELEASE = 3'd4,
    BL_RUN     = 3'd5,
    BL_ERROR   = 3'd6
  } bl_state_e;

  localparam int unsigned BL_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/bl_word_packer.sv
// Little-endian byte-to-word packer for the boot loader.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : store byte_i into the current byte lane and advance the lane index
//   clear_i       : return the lane index to byte 0 (word contents are kept)
//   byte_i        : incoming byte
//   word_o        : assembled word, first byte in bits [7:0]
//   full_o        : the next load completes the word (lane index is 3)
module bl_word_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clear_i) begin
      idx_q <= 2'd0;
    end else if (load_i) begin
      word_q[{idx_q, 3'b000} +: 8] <= byte_i;
      idx_q                        <= idx_q + 2'd1;
    end
  end

  assign word_o = word_q;
  assign full_o = (idx_q == 2'd3);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: holds the core in reset while a length-prefixed image
// (16-bit little-endian word count, then 4 bytes per word) arrives on a byte
// stream, writes the words to instruction memory from address 0, then releases
// the core.
// Ports:
//   clk, resetb         : clock, asynchronous active-low reset
//   rx_valid/rx_data    : incoming byte stream
//   rx_ready            : byte accepted this cycle when rx_valid is also high
//   reload              : single-cycle request to restart loading
//   im_we/im_waddr/im_wdata : instruction-memory write port, one strobe per word
//   core_resetb         : registered active-low core reset
//   busy                : loading in progress
//   err                 : sticky error (bad length or inter-byte timeout)
//   words_loaded        : words written in the current/last frame
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int unsigned IM_WORDS    = 1024,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = BL_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              core_resetb,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned WordsW = ADDR_W + 1;
  localparam int unsigned IdleW  = $clog2(TIMEOUT_CYC + 1);

  bl_state_e         state_q, state_d;
  logic [15:0]       length_q, length_d;
  logic [WordsW-1:0] words_q, words_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              rx_ready_q, im_we_q, core_resetb_q, busy_q, err_q;
  logic              xfer, pack_load, pack_clear, pack_full;
  logic [15:0]       len_rx;

  assign xfer   = rx_valid & rx_ready_q;
  assign len_rx = {rx_data, length_q[7:0]};

  bl_word_packer u_packer (
    .clk_i   (clk),
    .rst_ni  (resetb),
    .load_i  (pack_load),
    .clear_i (pack_clear),
    .byte_i  (rx_data),
    .word_o  (im_wdata),
    .full_o  (pack_full)
  );

  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    words_d    = words_q;
    idle_d     = '0;
    pack_load  = 1'b0;
    pack_clear = 1'b0;
    if (reload) begin
      // Any byte transferred alongside reload is dropped.
      state_d    = BL_LEN_LO;
      length_d   = '0;
      words_d    = '0;
      pack_clear = 1'b1;
    end else begin
      unique case (state_q)
        BL_LEN_LO: begin
          if (xfer) begin
            length_d[7:0] = rx_data;
            state_d       = BL_LEN_HI;
          end
        end
        BL_LEN_HI: begin
          if (xfer) begin
            length_d[15:8] = rx_data;
            if (len_rx == 16'd0) begin
              state_d = BL_RELEASE;
            end else if (32'(len_rx) > IM_WORDS) begin
              state_d = BL_ERROR;
            end else begin
              state_d = BL_DATA;
            end
          end else begin
            idle_d = idle_q + IdleW'(1);
            if (idle_d == IdleW'(TIMEOUT_CYC)) state_d = BL_ERROR;
          end
        end
        BL_DATA: begin
          if (xfer) begin
            pack_load = 1'b1;
            if (pack_full) state_d = BL_WRITE;
          end else begin
            idle_d = idle_q + IdleW'(1);
            if (idle_d == IdleW'(TIMEOUT_CYC)) state_d = BL_ERROR;
          end
        end
        BL_WRITE: begin
          words_d = words_q + WordsW'(1);
          state_d = (32'(words_d) == 32'(length_q)) ? BL_RELEASE : BL_DATA;
        end
        BL_RELEASE: state_d = BL_RUN;
        BL_RUN:     state_d = BL_RUN;
        BL_ERROR:   state_d = BL_ERROR;
        default:    state_d = BL_LEN_LO;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q       <= BL_LEN_LO;
      length_q      <= '0;
      words_q       <= '0;
      idle_q        <= '0;
      rx_ready_q    <= 1'b0;
      im_we_q       <= 1'b0;
      core_resetb_q <= 1'b0;
      busy_q        <= 1'b1;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      length_q      <= length_d;
      words_q       <= words_d;
      idle_q        <= idle_d;
      rx_ready_q    <= state_d inside {BL_LEN_LO, BL_LEN_HI, BL_DATA, BL_ERROR};
      im_we_q       <= (state_d == BL_WRITE);
      core_resetb_q <= (state_d == BL_RUN);
      busy_q        <= state_d inside {BL_LEN_LO, BL_LEN_HI, BL_DATA, BL_WRITE, BL_RELEASE};
      err_q         <= (state_d == BL_ERROR);
    end
  end

  assign rx_ready     = rx_ready_q;
  assign im_we        = im_we_q;
  assign im_waddr     = words_q[ADDR_W-1:0];
  assign core_resetb  = core_resetb_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: frame-level reference model,
// per-cycle output comparison, directed cases and randomized frames.
module tb_boot_loader_ctrl;

  localparam int unsigned IM_WORDS = 1024;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned TO       = 8;

  logic              clk_tb = 1'b0;
  logic              resetb;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              reload;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              core_resetb;
  logic              busy;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  always #5 clk_tb = ~clk_tb;

  boot_loader_ctrl #(
    .IM_WORDS    (IM_WORDS),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk_tb),
    .resetb       (resetb),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .reload       (reload),
    .im_we        (im_we),
    .im_waddr     (im_waddr),
    .im_wdata     (im_wdata),
    .core_resetb  (core_resetb),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk_tb) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks the frame in terms of header bytes seen, data bytes,
  // words written and release progress; expected outputs follow from those.
  int          m_hdr, m_len, m_nbytes, m_nwords, m_rel, m_idle;
  bit          m_err, m_wr;
  logic [31:0] m_word;
  bit          e_rdy, e_we, e_crb, e_busy, e_err;
  int          e_waddr, e_words;

  task automatic m_outputs();
    e_rdy   = m_err || (m_rel == 0 && !m_wr);
    e_we    = m_wr;
    e_waddr = m_nwords;
    e_crb   = (m_rel == 2);
    e_busy  = !m_err && (m_rel != 2);
    e_err   = m_err;
    e_words = m_nwords;
  endtask

  always @(posedge clk_tb or negedge resetb) begin
    if (!resetb) begin
      m_hdr = 0; m_len = 0; m_nbytes = 0; m_nwords = 0; m_rel = 0; m_idle = 0;
      m_err = 0; m_wr = 0; m_word = 32'd0;
      m_outputs();
      e_rdy  = 1'b0;
      e_busy = 1'b1;
    end else begin
      bit x;
      x = rx_valid && e_rdy;
      if (reload) begin
        m_hdr = 0; m_len = 0; m_nbytes = 0; m_nwords = 0; m_rel = 0; m_idle = 0;
        m_err = 0; m_wr = 0;
      end else if (m_err) begin
        // errored: bytes drained, nothing else changes
      end else if (m_rel != 0) begin
        m_rel = 2;
      end else if (m_wr) begin
        m_wr = 0;
        m_idle = 0;
        m_nwords++;
        if (m_nwords == m_len) m_rel = 1;
      end else if (x) begin
        m_idle = 0;
        if (m_hdr == 0) begin
          m_len = int'(rx_data);
          m_hdr = 1;
        end else if (m_hdr == 1) begin
          m_len = m_len + 256 * int'(rx_data);
          m_hdr = 2;
          if (m_len == 0) m_rel = 1;
          else if (m_len > int'(IM_WORDS)) m_err = 1;
        end else begin
          m_word[8*(m_nbytes%4) +: 8] = rx_data;
          m_nbytes++;
          if (m_nbytes % 4 == 0) m_wr = 1;
        end
      end else if (m_hdr != 0) begin
        m_idle++;
        if (m_idle == int'(TO)) m_err = 1;
      end
      m_outputs();
    end
  end

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t wr_log[$];
  int  last_we_cyc = 0, rise_cyc = 0, last_xfer_cyc = 0, xfer_cnt = 0;
  bit  prev_crb = 1'b0;

  always @(negedge clk_tb) begin
    chk("rx_ready", 32'(rx_ready), 32'(e_rdy));
    chk("im_we", 32'(im_we), 32'(e_we));
    chk("im_waddr", 32'(im_waddr), 32'(e_waddr));
    chk("core_resetb", 32'(core_resetb), 32'(e_crb));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("err", 32'(err), 32'(e_err));
    chk("words_loaded", 32'(words_loaded), 32'(e_words));
    if (e_we) chk("im_wdata", im_wdata, m_word);
    if (im_we) begin
      wr_log.push_back('{addr: int'(im_waddr), data: im_wdata});
      last_we_cyc = cyc;
    end
    if (core_resetb && !prev_crb) rise_cyc = cyc;
    prev_crb = core_resetb;
    if (rx_valid && rx_ready) begin
      xfer_cnt++;
      last_xfer_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk_tb);
    #2;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    int waited;
    got = 1'b0;
    waited = 0;
    rx_valid = 1'b1;
    rx_data = b;
    while (!got) begin
      @(negedge clk_tb);
      got = rx_ready;
      step();
      waited++;
      if (!got && waited > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_byte: rx_ready stayed 0 for %0d cycles, expected 1", waited);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    foreach (bl[i]) send_byte(bl[i]);
  endtask

  task automatic reload_pulse(input bit with_byte);
    reload = 1'b1;
    rx_valid = with_byte;
    rx_data = 8'($urandom);
    step();
    reload = 1'b0;
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    int len, nb, kind, i, guard, x0;

    resetb = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    reload = 1'b0;
    repeat (3) @(posedge clk_tb);
    @(negedge clk_tb);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_core_resetb", 32'(core_resetb), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    @(posedge clk_tb);
    #2;
    resetb = 1'b1;
    step();

    // Two-word image.
    wr_log.delete();
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_list(q);
    idle(4);
    chk("t1_nwrites", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("t1_addr0", 32'(wr_log[0].addr), 32'd0);
      chk("t1_data0", wr_log[0].data, 32'h0000_0013);
      chk("t1_addr1", 32'(wr_log[1].addr), 32'd1);
      chk("t1_data1", wr_log[1].data, 32'h0000_006F);
    end
    chk("t1_words", 32'(words_loaded), 32'd2);
    chk("t1_release_lat", 32'(rise_cyc - last_we_cyc), 32'd2);

    // Zero-length image.
    reload_pulse(1'b0);
    wr_log.delete();
    q = '{8'h00, 8'h00};
    send_list(q);
    idle(4);
    chk("t2_nwrites", 32'(wr_log.size()), 32'd0);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_core_resetb", 32'(core_resetb), 32'd1);
    chk("t2_release_lat", 32'(rise_cyc - last_xfer_cyc), 32'd2);

    // Oversize length: error, bytes drained.
    reload_pulse(1'b0);
    wr_log.delete();
    q = '{8'h01, 8'h04};
    send_list(q);
    idle(2);
    chk("t3_err", 32'(err), 32'd1);
    x0 = xfer_cnt;
    q = '{8'hAA, 8'hBB, 8'hCC};
    send_list(q);
    idle(2);
    chk("t3_drained", 32'(xfer_cnt - x0), 32'd3);
    chk("t3_core_resetb", 32'(core_resetb), 32'd0);
    chk("t3_nwrites", 32'(wr_log.size()), 32'd0);

    // Inter-byte timeout inside the data phase.
    reload_pulse(1'b0);
    wr_log.delete();
    q = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_list(q);
    idle(7);
    chk("t4_err_before", 32'(err), 32'd0);
    idle(1);
    chk("t4_err_after", 32'(err), 32'd1);
    chk("t4_nwrites", 32'(wr_log.size()), 32'd0);

    // Reload out of RUN, then a one-word image.
    reload_pulse(1'b0);
    q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_list(q);
    idle(4);
    chk("t5_run", 32'(core_resetb), 32'd1);
    wr_log.delete();
    reload_pulse(1'b1);
    chk("t5_core_reset_fall", 32'(core_resetb), 32'd0);
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_list(q);
    idle(4);
    chk("t5_nwrites", 32'(wr_log.size()), 32'd1);
    if (wr_log.size() == 1) begin
      chk("t5_addr", 32'(wr_log[0].addr), 32'd0);
      chk("t5_data", wr_log[0].data, 32'hDEAD_BEEF);
    end
    chk("t5_core_resetb", 32'(core_resetb), 32'd1);

    // rx_valid held high through a three-word frame and beyond.
    reload_pulse(1'b0);
    wr_log.delete();
    q = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
          8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    x0 = xfer_cnt;
    i = 0;
    guard = 0;
    rx_valid = 1'b1;
    while (i < 14 && guard < 100) begin
      rx_data = q[i];
      @(negedge clk_tb);
      if (rx_ready) i++;
      step();
      guard++;
    end
    rx_data = 8'h55;
    repeat (8) step();
    rx_valid = 1'b0;
    chk("t6_xfers", 32'(xfer_cnt - x0), 32'd14);
    chk("t6_words", 32'(words_loaded), 32'd3);
    chk("t6_nwrites", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) chk("t6_data2", wr_log[2].data, 32'h0C0B_0A09);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      reload_pulse(1'($urandom_range(0, 1)));
      kind = $urandom_range(0, 9);
      if (kind == 0) len = $urandom_range(1025, 65535);
      else if (kind == 1) len = 0;
      else len = $urandom_range(1, 5);
      send_byte(8'(len));
      idle($urandom_range(0, 2));
      send_byte(8'(len >> 8));
      if (len > int'(IM_WORDS)) begin
        repeat ($urandom_range(0, 4)) send_byte(8'($urandom));
        idle(3);
        continue;
      end
      nb = 4 * len;
      if (kind == 2) nb = $urandom_range(0, 4 * len - 1);
      for (int b = 0; b < nb; b++) begin
        send_byte(8'($urandom));
        if ($urandom_range(0, 24) == 0) idle(TO);
        else idle($urandom_range(0, 2));
      end
      if (kind == 2) idle(TO + 2);
      else idle(4);
    end

    // Asynchronous reset in the middle of a frame.
    reload_pulse(1'b0);
    q = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
    send_list(q);
    resetb = 1'b0;
    step();
    step();
    chk("t7_rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd1);
    chk("t7_rst_words", 32'(words_loaded), 32'd0);
    resetb = 1'b1;
    step();
    wr_log.delete();
    q = '{8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_list(q);
    idle(4);
    chk("t7_core_resetb", 32'(core_resetb), 32'd1);
    if (wr_log.size() == 1) chk("t7_data", wr_log[0].data, 32'hD4C3_B2A1);
    else chk("t7_nwrites", 32'(wr_log.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
